// File: rtl/systolic_pe_array.sv
// systolic_pe_array: linear weight-stationary systolic array of P processing elements.
//
// The array advances once every PE_DIV sys_clk cycles. Each step does three things:
//   - every PE captures its weight lane
//   - a 2*(P-1)-deep x delay line shifts
//   - partial sums ripple one PE down the chain
// Once the pipeline has filled and the weights are held constant, the output after step
// edge n+P-1 is y(n) + sum_k W[k]*x(n-k).
//
// Optional feature: define PE_ARRAY_SAT_EN to make every product and addition saturate at
// 2^ELEMENT_BITS-1. When it is undefined, all arithmetic is modulo 2^ELEMENT_BITS.
//
// Ports:
//   sys_clk          in   single clock, rising edge
//   reset            in   synchronous active-high reset
//   weight_data_in   in   P lanes of ELEMENT_BITS; lane k is the weight for PE k
//   input_data_in    in   x element entering PE 0
//   output_data_in   in   partial sum y entering PE 0
//   output_data_out  out  partial sum leaving PE P-1 (registered)
//   pe_step          out  one-cycle strobe marking the cycle in which the array advances
module systolic_pe_array #(
  parameter int unsigned ELEMENT_BITS = 8,
  parameter int unsigned P            = 4,
  parameter int unsigned PE_DIV       = 5
) (
  input  logic                      sys_clk,
  input  logic                      reset,
  input  logic [P*ELEMENT_BITS-1:0] weight_data_in,
  input  logic [ELEMENT_BITS-1:0]   input_data_in,
  input  logic [ELEMENT_BITS-1:0]   output_data_in,
  output logic [ELEMENT_BITS-1:0]   output_data_out,
  output logic                      pe_step
);

  localparam int unsigned DelayLen = 2 * (P - 1);
  localparam int unsigned CntW     = (PE_DIV > 1) ? $clog2(PE_DIV) : 1;

  // Arithmetic helpers: truncating/wrapping by default, saturating when enabled.
  function automatic logic [ELEMENT_BITS-1:0] mul_op(input logic [ELEMENT_BITS-1:0] a,
                                                     input logic [ELEMENT_BITS-1:0] b);
`ifdef PE_ARRAY_SAT_EN
    logic [2*ELEMENT_BITS-1:0] prod;
    prod = {{ELEMENT_BITS{1'b0}}, a} * {{ELEMENT_BITS{1'b0}}, b};
    mul_op = (|prod[2*ELEMENT_BITS-1:ELEMENT_BITS]) ? '1 : prod[ELEMENT_BITS-1:0];
`else
    mul_op = a * b;
`endif
  endfunction

  function automatic logic [ELEMENT_BITS-1:0] add_op(input logic [ELEMENT_BITS-1:0] a,
                                                     input logic [ELEMENT_BITS-1:0] b);
`ifdef PE_ARRAY_SAT_EN
    logic [ELEMENT_BITS:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    add_op = sum[ELEMENT_BITS] ? '1 : sum[ELEMENT_BITS-1:0];
`else
    add_op = a + b;
`endif
  endfunction

  // Step generator
  logic [CntW-1:0] cnt_q;

  assign pe_step = (cnt_q == CntW'(PE_DIV - 1));

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (pe_step) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Array state
  logic [ELEMENT_BITS-1:0] w_q   [P];
  logic [ELEMENT_BITS-1:0] x_q   [DelayLen];
  logic [ELEMENT_BITS-1:0] s_q   [P];
  logic [ELEMENT_BITS-1:0] s_d   [P];
  logic [ELEMENT_BITS-1:0] tap   [P];

  // Each PE k sees x delayed by 2k steps. Partial sums move one PE per step, so the extra
  // step of delay lines the x samples up with the sum travelling alongside them.
  // x_q[j] holds x delayed by j+1 steps.
  always_comb begin
    tap[0] = input_data_in;
    for (int unsigned k = 1; k < P; k++) begin
      tap[k] = x_q[2*k-1];
    end
    s_d[0] = add_op(output_data_in, mul_op(w_q[0], tap[0]));
    for (int unsigned k = 1; k < P; k++) begin
      s_d[k] = add_op(s_q[k-1], mul_op(w_q[k], tap[k]));
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < P; k++) begin
        w_q[k] <= '0;
        s_q[k] <= '0;
      end
      for (int unsigned j = 0; j < DelayLen; j++) begin
        x_q[j] <= '0;
      end
    end else if (pe_step) begin
      for (int unsigned k = 0; k < P; k++) begin
        w_q[k] <= weight_data_in[k*ELEMENT_BITS +: ELEMENT_BITS];
        s_q[k] <= s_d[k];
      end
      x_q[0] <= input_data_in;
      for (int unsigned j = 1; j < DelayLen; j++) begin
        x_q[j] <= x_q[j-1];
      end
    end
  end

  assign output_data_out = s_q[P-1];

endmodule

// File: tb/tb_systolic_pe_array.sv
// tb_systolic_pe_array: directed self-checking bench for systolic_pe_array (P=4, PE_DIV=5).
module tb_systolic_pe_array;

  localparam int unsigned Eb = 8;
  localparam int unsigned Np = 4;
  localparam int unsigned Div = 5;

  logic            sys_clk = 1'b0;
  logic            reset = 1'b1;
  logic [Np*Eb-1:0] weight_data_in = '0;
  logic [Eb-1:0]   input_data_in = '0;
  logic [Eb-1:0]   output_data_in = '0;
  logic [Eb-1:0]   output_data_out;
  logic            pe_step;

  int checks = 0;
  int failures = 0;

  systolic_pe_array #(
    .ELEMENT_BITS(Eb),
    .P(Np),
    .PE_DIV(Div)
  ) dut (
    .sys_clk(sys_clk),
    .reset(reset),
    .weight_data_in(weight_data_in),
    .input_data_in(input_data_in),
    .output_data_in(output_data_in),
    .output_data_out(output_data_out),
    .pe_step(pe_step)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Hold reset for n cycles, checking outputs during reset, then release.
  task automatic do_reset(input int n);
    @(negedge sys_clk);
    reset = 1'b1;
    repeat (n) begin
      @(posedge sys_clk);
      #1;
      check("rst_out", {24'd0, output_data_out}, 32'd0);
      check("rst_step", {31'd0, pe_step}, 32'd0);
    end
    reset = 1'b0;
  endtask

  // After release, pe_step must first appear in the 5th cycle. Consumes step edge 1.
  task automatic check_first_step();
    for (int c = 1; c <= 5; c++) begin
      @(negedge sys_clk);
      check($sformatf("first_step_c%0d", c), {31'd0, pe_step}, (c == 5) ? 32'd1 : 32'd0);
    end
    @(posedge sys_clk);
    #1;
  endtask

  // Advance to just after the next step edge, with a bounded wait.
  task automatic step();
    int n;
    n = 0;
    @(negedge sys_clk);
    while (!pe_step && n < 4 * Div) begin
      n++;
      @(negedge sys_clk);
    end
    if (!pe_step) begin
      check("step_timeout", {31'd0, pe_step}, 32'd1);
    end
    @(posedge sys_clk);
    #1;
  endtask

  // Run step edges 2..last and check the output from edge first_chk onward.
  task automatic run_const(input string tag, input int first_chk, input int last,
                           input logic [7:0] exp);
    for (int s = 2; s <= last; s++) begin
      step();
      if (s >= first_chk) check($sformatf("%s_s%0d", tag, s), {24'd0, output_data_out},
                                {24'd0, exp});
    end
  endtask

  initial begin
    // Reset values and the constant stream: 3 + 4*(1*2) = 11.
    weight_data_in = 32'h01010101;
    input_data_in = 8'd2;
    output_data_in = 8'd3;
    do_reset(3);
    check_first_step();
    run_const("const", 9, 12, 8'd11);

    // Mid-stream reset: output clears next cycle, counter restarts, steady value returns.
    @(negedge sys_clk);
    reset = 1'b1;
    @(posedge sys_clk);
    #1;
    check("mid_rst_out", {24'd0, output_data_out}, 32'd0);
    check("mid_rst_step", {31'd0, pe_step}, 32'd0);
    reset = 1'b0;
    check_first_step();
    check("refill_s1", {24'd0, output_data_out}, 32'd0);
    run_const("refill", 9, 11, 8'd11);

    // Impulse response: x=1 sampled at step 10 only.
    weight_data_in = 32'h04030201;
    input_data_in = 8'd0;
    output_data_in = 8'd0;
    do_reset(2);
    check_first_step();
    for (int s = 2; s <= 18; s++) begin
      input_data_in = (s == 10) ? 8'd1 : 8'd0;
      step();
      if (s >= 11) begin
        check($sformatf("impulse_s%0d", s), {24'd0, output_data_out},
              (s >= 13 && s <= 16) ? 32'(s - 12) : 32'd0);
      end
    end

    // Wrap / saturate: each product 255*2, four products summed.
    weight_data_in = 32'hFFFFFFFF;
    input_data_in = 8'd2;
    output_data_in = 8'd0;
    do_reset(2);
    check_first_step();
`ifdef PE_ARRAY_SAT_EN
    run_const("sat", 9, 11, 8'hFF);
`else
    run_const("wrap", 9, 11, 8'hF8);
`endif

    // Step gating: inputs hold good values only in pe_step cycles, garbage otherwise.
    weight_data_in = 32'h01010101;
    input_data_in = 8'd2;
    output_data_in = 8'd3;
    do_reset(2);
    check_first_step();
    begin
      int steps;
      int cyc;
      logic st;
      steps = 1;
      cyc = 0;
      while (steps < 13 && cyc < 200) begin
        @(negedge sys_clk);
        st = pe_step;
        if (st) begin
          input_data_in = 8'd2;
          weight_data_in = 32'h01010101;
          output_data_in = 8'd3;
        end else begin
          input_data_in = 8'hA5 ^ 8'(cyc);
          weight_data_in = 32'h5A3C7E11 ^ 32'(cyc);
          output_data_in = 8'h77 ^ 8'(cyc);
        end
        @(posedge sys_clk);
        #1;
        if (st) begin
          steps++;
          if (steps >= 10) begin
            check($sformatf("gated_s%0d", steps), {24'd0, output_data_out}, 32'd11);
          end
        end
        cyc++;
      end
      if (steps < 13) check("gated_timeout", 32'(steps), 32'd13);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
